// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared defaults and sweep FSM encoding for the register file
package regfile_mp_pkg;
  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_ADDR_BITS  = 5;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_NUM_RD     = 2;
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;
  typedef enum logic {CLEAR = ST_CLEAR, RUN = ST_RUN} state_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-load bits with set-over-clear priority and per-port lookup
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int NUM_RD    = DEF_NUM_RD
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        set_en,
  input  logic [ADDR_BITS-1:0]        set_addr,
  input  logic                        clr_en,
  input  logic [ADDR_BITS-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_BITS-1:0] rd_addr,
  output logic [NUM_RD-1:0]           busy
);
  logic [NUM_REGS-1:0] pend, set_mask, clr_mask;
  logic [2**ADDR_BITS-1:0] pend_ext;
  assign set_mask = set_en ? (NUM_REGS'(1) << set_addr) & ~NUM_REGS'(1) : '0;
  assign clr_mask = clr_en ? NUM_REGS'(1) << clr_addr : '0;
  assign pend_ext = (2**ADDR_BITS)'(pend);
  // Set is applied after clear so a new reservation survives a same-cycle load return
  always_ff @(posedge clk)
    if (rst) pend <= '0;
    else pend <= pend & ~clr_mask | set_mask;
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign busy[i] = pend_ext[rd_addr[i*ADDR_BITS +: ADDR_BITS]];
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with load scoreboard and post-reset clear sweep; REGFILE_BYPASS_EN enables write-through forwarding
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int NUM_RD     = DEF_NUM_RD
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_BITS-1:0]  rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         w0_en,
  input  logic [ADDR_BITS-1:0]         w0_addr,
  input  logic [DATA_WIDTH-1:0]        w0_data,
  input  logic                         w1_en,
  input  logic [ADDR_BITS-1:0]         w1_addr,
  input  logic [DATA_WIDTH-1:0]        w1_data,
  input  logic                         rsv_en,
  input  logic [ADDR_BITS-1:0]         rsv_addr,
  output logic                         ready
);
  state_t state, state_n;
  logic [ADDR_BITS-1:0] ptr;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic run, w0_hit, w1_hit;
  logic [NUM_RD-1:0] busy;
  function automatic logic addr_ok(input logic [ADDR_BITS-1:0] a);
    return a != '0 && {1'b0, a} < (ADDR_BITS+1)'(NUM_REGS);
  endfunction
  assign run    = state == RUN;
  assign ready  = run;
  assign w0_hit = run && w0_en && addr_ok(w0_addr);
  assign w1_hit = run && w1_en && addr_ok(w1_addr);
  // State and sweep pointer; reset restarts the sweep at register 1
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR;
      ptr   <= ADDR_BITS'(1);
    end else begin
      state <= state_n;
      if (!run) ptr <= ptr + 1'b1;
    end
  // Sweep ends on the cycle the last register is cleared
  always_comb state_n = (!run && ptr == ADDR_BITS'(NUM_REGS-1)) ? RUN : state;
  // Array update: sweep clears one entry per cycle, in RUN w1 is written last so it wins a collision
  always_ff @(posedge clk)
    if (!rst) begin
      if (!run) regs[ptr] <= '0;
      if (w0_hit) regs[w0_addr] <= w0_data;
      if (w1_hit) regs[w1_addr] <= w1_data;
    end
  regfile_scoreboard #(
    .ADDR_BITS(ADDR_BITS),
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (run && rsv_en),
    .set_addr(rsv_addr),
    .clr_en  (run && w1_en),
    .clr_addr(w1_addr),
    .rd_addr (rd_addr),
    .busy    (busy)
  );
  assign rd_busy = run ? busy : '0;
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_BITS-1:0] a;
    logic [DATA_WIDTH-1:0] q;
    assign a = rd_addr[i*ADDR_BITS +: ADDR_BITS];
`ifdef REGFILE_BYPASS_EN
    assign q = w1_hit && w1_addr == a ? w1_data : w0_hit && w0_addr == a ? w0_data : regs[a];
`else
    assign q = regs[a];
`endif
    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = run && addr_ok(a) ? q : '0;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp
module tb_regfile_mp;
  localparam int DW = 24, AB = 5, NR = 32, NRD = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    string       tag;
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [NRD*AB-1:0] rd_addr = '0;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic w0_en = 1'b0, w1_en = 1'b0, rsv_en = 1'b0, ready;
  logic [AB-1:0] w0_addr = '0, w1_addr = '0, rsv_addr = '0;
  logic [DW-1:0] w0_data = '0, w1_data = '0;
  exp_t q[$];
  int vectors = 0, errors = 0;
  int n, m;
  always #5 clk = ~clk;
  regfile_mp #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .ready(ready)
  );
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic expect_d(input string tag, input int port, input logic [31:0] exp);
    q.push_back('{tag, 0, port, exp});
  endtask
  task automatic expect_b(input string tag, input int port, input logic [31:0] exp);
    q.push_back('{tag, 1, port, exp});
  endtask
  task automatic check_q;
    exp_t e;
    logic [31:0] obs;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      obs = e.kind == 0 ? 32'(rd_data[e.port*DW +: DW]) : 32'(rd_busy[e.port]);
      cmp(e.tag, obs, e.exp);
    end
  endtask
  task automatic set_rd(input logic [AB-1:0] a0, input logic [AB-1:0] a1);
    rd_addr = {a1, a0};
  endtask
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    cmp("reset_ready", 32'(ready), 32'd0);
    w0_en = 1'b1; w0_addr = 5'd3; w0_data = 24'hFFFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    set_rd(5'd3, 5'd3);
    for (int i = 0; i < 20; i++) begin
      if (i == 15) begin
        expect_d("clear_rd", 0, 32'h0);
        expect_b("clear_busy", 0, 32'h0);
        check_q();
        cmp("clear_ready", 32'(ready), 32'd0);
      end
      tick();
    end
    w0_en = 1'b0; rsv_en = 1'b0;
    wait_ready(m);
    cmp("sweep_len", 32'(20 + m), 32'd31);
    expect_d("clear_r3", 0, 32'h0);
    expect_b("clear_r3_busy", 0, 32'h0);
    check_q();
    for (int a = 0; a < NR; a++) begin
      set_rd(AB'(a), AB'(NR - 1 - a));
      expect_d("swept_p0", 0, 32'h0);
      expect_d("swept_p1", 1, 32'h0);
      check_q();
    end
    w0_en = 1'b1; w0_addr = 5'd5; w0_data = 24'hABCDEF;
    set_rd(5'd5, 5'd0);
    expect_d("wr_same_cycle", 0, BYP ? 32'hABCDEF : 32'h0);
    expect_d("r0_zero", 1, 32'h0);
    check_q();
    tick();
    w0_en = 1'b0;
    expect_d("wr_next_cycle", 0, 32'hABCDEF);
    expect_d("r0_zero2", 1, 32'h0);
    check_q();
    w0_en = 1'b1; w0_addr = 5'd7; w0_data = 24'h111111;
    w1_en = 1'b1; w1_addr = 5'd7; w1_data = 24'h222222;
    set_rd(5'd7, 5'd5);
    expect_d("coll_same_cycle", 0, BYP ? 32'h222222 : 32'h0);
    check_q();
    tick();
    w1_en = 1'b0;
    w0_addr = 5'd0; w0_data = 24'h333333;
    set_rd(5'd7, 5'd0);
    expect_d("coll_w1_wins", 0, 32'h222222);
    expect_d("w_r0_same", 1, 32'h0);
    check_q();
    tick();
    w0_en = 1'b0;
    expect_d("w_r0_after", 1, 32'h0);
    expect_d("r5_kept", 0, 32'h0);
    set_rd(5'd5, 5'd0);
    q[1].exp = 32'hABCDEF;
    check_q();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    set_rd(5'd9, 5'd9);
    expect_b("rsv_no_bypass", 0, 32'h0);
    check_q();
    tick();
    rsv_en = 1'b0;
    expect_b("rsv_busy_p0", 0, 32'h1);
    expect_b("rsv_busy_p1", 1, 32'h1);
    check_q();
    w1_en = 1'b1; w1_addr = 5'd9; w1_data = 24'h000999;
    expect_b("rel_same_cycle", 0, 32'h1);
    check_q();
    tick();
    w1_en = 1'b0;
    expect_b("rel_busy", 0, 32'h0);
    expect_d("rel_data", 1, 32'h000999);
    check_q();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    w1_en = 1'b1; w1_addr = 5'd9; w1_data = 24'h000777;
    tick();
    rsv_en = 1'b0; w1_en = 1'b0;
    expect_b("set_wins", 0, 32'h1);
    expect_d("set_wins_data", 1, 32'h000777);
    check_q();
    rsv_en = 1'b1; rsv_addr = 5'd0;
    tick();
    rsv_en = 1'b0;
    set_rd(5'd0, 5'd9);
    expect_b("rsv_r0", 0, 32'h0);
    expect_b("r9_still", 1, 32'h1);
    check_q();
    w0_en = 1'b1; w0_addr = 5'd4; w0_data = 24'h0000AA;
    rsv_en = 1'b1; rsv_addr = 5'd4;
    tick();
    w0_en = 1'b0; rsv_en = 1'b0;
    set_rd(5'd4, 5'd9);
    expect_d("r4_data", 0, 32'h0000AA);
    expect_b("r4_busy", 0, 32'h1);
    check_q();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("runrst_ready", 32'(ready), 32'd0);
    expect_d("runrst_r4", 0, 32'h0);
    expect_b("runrst_busy", 0, 32'h0);
    expect_b("runrst_busy9", 1, 32'h0);
    check_q();
    for (int i = 0; i < 10; i++) tick();
    cmp("midsweep_ready", 32'(ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(n);
    cmp("resweep_len", 32'(n), 32'd31);
    expect_d("post_r4", 0, 32'h0);
    expect_b("post_busy4", 0, 32'h0);
    expect_b("post_busy9", 1, 32'h0);
    check_q();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
